dip_median_5x5_ctrl: RTL and testbench

Frame sequencer for the 5x5 median filter. It accepts a raster pixel stream with a valid/ready handshake and drives the line-buffer write and window-shift strobes. It also tracks the coordinates of the window centre, flags border centres, and delays valid and sideband signals so they line up with the sorter-network output. It sits between the pixel source and the line-buffer/sorting datapath, and owns the only global stall (`pipe_en`) in the filter.

---
 rtl/dip_median_pkg.sv | 29 ++
 rtl/dip_side_dly.sv | 31 +++
 rtl/dip_median_5x5_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dip_median_5x5_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dip_median_pkg.sv
// Shared types and constants for the 5x5 median filter control path.
package dip_median_pkg;

  // Window radius: a 5x5 window reaches two pixels either side of its centre.
  localparam int unsigned WIN_RAD = 32'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_e;

  // Sideband that travels alongside the sorter network.
  typedef struct packed {
    logic vld;
    logic border;
    logic sof;
    logic eol;
    logic eof;
  } side_t;

  // Window shifts needed before the first centre (0,0) is in the middle of
  // the window: two full lines plus two pixels.
  function automatic int unsigned flush_len(input int unsigned img_w);
    return WIN_RAD * img_w + WIN_RAD;
  endfunction

endpackage

// File: rtl/dip_side_dly.sv
// Sideband delay line matching the sorter-network latency.
module dip_side_dly
  import dip_median_pkg::*;
#(
  parameter int unsigned DEPTH = 6
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  sw_rst_n,
  input  logic  en,
  input  side_t d,
  output side_t q
);

  side_t stg_r [DEPTH];

  // Shift one stage per enabled cycle; either reset empties every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stg_r[i] <= '0;
    end else if (!sw_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stg_r[i] <= '0;
    end else if (en) begin
      stg_r[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stg_r[i] <= stg_r[i-1];
    end
  end

  assign q = stg_r[DEPTH-1];

endmodule

// File: rtl/dip_median_5x5_ctrl.sv
// Frame sequencer for the 5x5 median filter: input handshake, line-buffer
// and window strobes, centre coordinate tracking and output sideband.
module dip_median_5x5_ctrl
  import dip_median_pkg::*;
#(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned SORT_LAT = 6,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             out_rdy,
  output logic             pipe_en,
  output logic             lb_wr_en,
  output logic [CNT_W-1:0] lb_col,
  output logic             win_shift,
  output logic             out_vld,
  output logic             out_border,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int unsigned      S_W        = 2 * CNT_W;
  localparam logic [S_W-1:0]   F_C        = S_W'(flush_len(IMG_W));
  // Total shifts per frame: every input pixel plus the flush shifts.
  localparam logic [S_W-1:0]   S_END_C    = S_W'(IMG_W * IMG_H + flush_len(IMG_W));
  localparam logic [CNT_W-1:0] COL_LAST_C = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST_C = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] COL_HI_C   = CNT_W'(IMG_W - 1 - WIN_RAD);
  localparam logic [CNT_W-1:0] ROW_HI_C   = CNT_W'(IMG_H - 1 - WIN_RAD);
  localparam logic [CNT_W-1:0] EDGE_C     = CNT_W'(WIN_RAD);

  ctrl_state_e      state_r, state_s;
  logic [CNT_W-1:0] in_col_r, in_row_r;
  logic [CNT_W-1:0] ctr_col_r, ctr_row_r;
  logic [S_W-1:0]   s_r, s_next_s;
  logic             done_r;
  logic             pipe_en_s, in_rdy_s, lb_wr_en_s, win_shift_s;
  logic             start_acc_s, done_set_s, eof_hs_s, ctr_vld_s;
  side_t            side_d_s, side_q_s;

  assign pipe_en_s = out_rdy | ~side_q_s.vld;
  assign eof_hs_s  = side_q_s.vld & side_q_s.eof & out_rdy;
  assign s_next_s  = s_r + S_W'(1);
  // Centre index s-F is valid for exactly IMG_W*IMG_H shifts.
  assign ctr_vld_s = win_shift_s & (s_next_s >= F_C) & (s_next_s < S_END_C);

  // Next-state and strobe decode.
  always_comb begin
    state_s     = state_r;
    in_rdy_s    = 1'b0;
    lb_wr_en_s  = 1'b0;
    win_shift_s = 1'b0;
    start_acc_s = 1'b0;
    done_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = RUN;
          start_acc_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        in_rdy_s = pipe_en_s;
        if (in_vld && pipe_en_s) begin
          lb_wr_en_s  = 1'b1;
          win_shift_s = 1'b1;
          if (in_col_r == COL_LAST_C && in_row_r == ROW_LAST_C) begin
            state_s = FLUSH;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        win_shift_s = pipe_en_s;
        // With a very short sorter the final output can leave during flush.
        if (eof_hs_s) begin
          state_s    = IDLE;
          done_set_s = 1'b1;
        end else if (pipe_en_s && s_next_s == S_END_C) begin
          state_s = DRAIN;
        end else begin
          state_s = FLUSH;
        end
      end
      DRAIN: begin
        if (eof_hs_s) begin
          state_s    = IDLE;
          done_set_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Sideband for the centre entering the sorter this cycle.
  always_comb begin
    side_d_s = '0;
    if (ctr_vld_s) begin
      side_d_s.vld    = 1'b1;
      side_d_s.border = (ctr_col_r < EDGE_C) | (ctr_col_r > COL_HI_C) |
                        (ctr_row_r < EDGE_C) | (ctr_row_r > ROW_HI_C);
      side_d_s.sof    = (ctr_col_r == '0) & (ctr_row_r == '0);
      side_d_s.eol    = (ctr_col_r == COL_LAST_C);
      side_d_s.eof    = (ctr_col_r == COL_LAST_C) & (ctr_row_r == ROW_LAST_C);
    end else begin
      side_d_s = '0;
    end
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else if (!sw_rst_n) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_set_s;
    end
  end

  // Input raster, shift count and centre raster counters; cleared per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col_r  <= '0;
      in_row_r  <= '0;
      s_r       <= '0;
      ctr_col_r <= '0;
      ctr_row_r <= '0;
    end else if (!sw_rst_n || start_acc_s) begin
      in_col_r  <= '0;
      in_row_r  <= '0;
      s_r       <= '0;
      ctr_col_r <= '0;
      ctr_row_r <= '0;
    end else begin
      if (lb_wr_en_s) begin
        if (in_col_r == COL_LAST_C) begin
          in_col_r <= '0;
          in_row_r <= in_row_r + CNT_W'(1);
        end else begin
          in_col_r <= in_col_r + CNT_W'(1);
        end
      end
      if (win_shift_s) s_r <= s_next_s;
      if (ctr_vld_s) begin
        if (ctr_col_r == COL_LAST_C) begin
          ctr_col_r <= '0;
          ctr_row_r <= ctr_row_r + CNT_W'(1);
        end else begin
          ctr_col_r <= ctr_col_r + CNT_W'(1);
        end
      end
    end
  end

  dip_side_dly #(.DEPTH(SORT_LAT)) u_side_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_rst_n (sw_rst_n),
    .en       (pipe_en_s),
    .d        (side_d_s),
    .q        (side_q_s)
  );

  assign busy       = (state_r != IDLE);
  assign done       = done_r;
  assign in_rdy     = in_rdy_s;
  assign pipe_en    = pipe_en_s;
  assign lb_wr_en   = lb_wr_en_s;
  assign lb_col     = in_col_r;
  assign win_shift  = win_shift_s;
  assign out_vld    = side_q_s.vld;
  assign out_border = side_q_s.border;
  assign out_sof    = side_q_s.sof;
  assign out_eol    = side_q_s.eol;
  assign out_eof    = side_q_s.eof;

endmodule

// File: tb/tb_dip_median_5x5_ctrl.sv
// Self-checking bench for dip_median_5x5_ctrl on an 8x6 frame.
module tb_dip_median_5x5_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int L = 3;
  localparam int F = 2 * W + 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n, sw_rst_n, start, in_vld, out_rdy;
  logic        busy, done, in_rdy, pipe_en, lb_wr_en, win_shift;
  logic [11:0] lb_col;
  logic        out_vld, out_border, out_sof, out_eol, out_eof;

  int errors = 0;
  int checks = 0;

  logic [3:0] q[$];
  bit   mon_on = 0, quiet = 0, lat_chk = 0, frame_done = 0, first_seen = 0;
  bit   prev_done = 0, prev_stall = 0;
  logic [4:0] prev_bundle = '0;
  int   cyc = 0, n_out = 0, n_done = 0, n_int = 0, n_shift = 0, n_wr = 0;
  int   exp_col = 0, shift_f_cyc = 0;

  dip_median_5x5_ctrl #(.IMG_W(W), .IMG_H(H), .SORT_LAT(L), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_n(sw_rst_n), .start(start),
    .busy(busy), .done(done), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_rdy(out_rdy), .pipe_en(pipe_en), .lb_wr_en(lb_wr_en),
    .lb_col(lb_col), .win_shift(win_shift), .out_vld(out_vld),
    .out_border(out_border), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {border, sof, eol, eof} for centre k in raster order.
  function automatic logic [3:0] exp_bits(input int k);
    int   c;
    int   r;
    logic b;
    c = k % W;
    r = k / W;
    b = (c < 2) || (c > W - 3) || (r < 2) || (r > H - 3);
    return {b, (k == 0), (c == W - 1), (k == N - 1)};
  endfunction

  // Cycle monitor: handshake rules, stall stability, scoreboard pops.
  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (quiet) begin
        chk("quiet_out_vld", out_vld, 0);
        chk("quiet_done", done, 0);
      end
      if (prev_stall)
        chk("stall_hold", {out_vld, out_border, out_sof, out_eol, out_eof}, prev_bundle);
      if (out_vld && !out_rdy) chk("stall_in_rdy", in_rdy, 0);
      if (win_shift) begin
        n_shift++;
        if (n_shift == F) shift_f_cyc = cyc;
      end
      if (win_shift && n_wr < N) chk("shift_needs_hs", lb_wr_en && in_vld && in_rdy, 1);
      if (lb_wr_en) begin
        chk("lb_col", lb_col, exp_col);
        exp_col = (exp_col + 1) % W;
        n_wr++;
      end
      if (out_vld && lat_chk && !first_seen) begin
        first_seen = 1;
        chk("first_latency", cyc - shift_f_cyc, L);
      end
      if (out_vld && out_rdy) begin
        n_out++;
        chk("outq_avail", q.size() != 0, 1);
        if (q.size() != 0) chk("out_side", {out_border, out_sof, out_eol, out_eof}, q.pop_front());
        if (!out_border) n_int++;
      end
      if (done) begin
        n_done++;
        chk("done_single", prev_done, 0);
        chk("busy_fall", busy, 0);
        frame_done = 1;
      end
      prev_done   = done;
      prev_stall  = out_vld && !out_rdy;
      prev_bundle = {out_vld, out_border, out_sof, out_eol, out_eof};
    end
  end

  // vld_mode 1: in_vld low one cycle in three; rdy_mode 1: random out_rdy.
  // abort_at >= 0: soft reset after that many inputs; restart_at >= 0:
  // extra start pulse after that many inputs.
  task automatic run_frame(input int vld_mode, input int rdy_mode,
                           input int abort_at, input int restart_at);
    int n_in;
    int cyc_l;
    bit used;
    q.delete();
    for (int k = 0; k < N; k++) q.push_back(exp_bits(k));
    n_out = 0; n_done = 0; n_int = 0; n_shift = 0; n_wr = 0; exp_col = 0;
    first_seen = 0; frame_done = 0;
    n_in = 0; cyc_l = 0; used = 0;
    @(posedge clk); #1;
    start = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_rise", busy, 1);
    while (!frame_done && cyc_l < 3000) begin
      @(posedge clk); #1;
      start   = (restart_at >= 0 && !used && n_in >= restart_at);
      if (start) used = 1;
      in_vld  = (vld_mode == 0) ? 1'b1 : (cyc_l % 3 != 2);
      out_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (in_vld && in_rdy) n_in++;
      cyc_l++;
      if (abort_at >= 0 && n_in >= abort_at) break;
    end
    if (abort_at >= 0) begin
      @(posedge clk); #1;
      sw_rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      sw_rst_n = 1'b1; quiet = 1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      repeat (60) @(negedge clk);
      quiet = 0;
      chk("abort_no_done", n_done, 0);
      q.delete();
    end else begin
      @(posedge clk); #1;
      in_vld = 1'b0; start = 1'b0; out_rdy = 1'b1;
      chk("frame_finished", frame_done, 1);
      chk("out_count", n_out, N);
      chk("done_count", n_done, 1);
      chk("queue_empty", q.size(), 0);
      chk("interior_count", n_int, (W - 4) * (H - 4));
      chk("write_count", n_wr, N);
    end
  endtask

  initial begin
    rst_n = 1'b0; sw_rst_n = 1'b1; start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_lb_wr_en", lb_wr_en, 0);
    chk("rst_win_shift", win_shift, 0);
    chk("rst_lb_col", lb_col, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_side", {out_border, out_sof, out_eol, out_eof}, 0);
    chk("rst_pipe_en", pipe_en, 1);
    mon_on = 1;

    lat_chk = 1;
    run_frame(0, 0, -1, -1);
    lat_chk = 0;
    run_frame(0, 1, -1, -1);
    run_frame(1, 0, -1, -1);
    run_frame(0, 0, 20, -1);
    run_frame(1, 1, -1, -1);
    run_frame(0, 0, -1, 10);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
